glossy_relay_responder: RTL

//  Receiver/relay end of the Glossy flood link on the WIDTH-bit parallel symbol line.

---
 rtl/glossy_relay_responder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/glossy_relay_responder.sv
// Glossy flood relay end: captures one frame, verifies length and XOR checksum,
// waits a fixed turnaround, then retransmits it with the relay counter bumped.
module glossy_relay_responder #(
    parameter int WIDTH       = 10,
    parameter int MAX_LEN     = 16,
    parameter int TURN_CYCLES = 8,
    parameter int RX_TIMEOUT  = 32,
    parameter int RELAY_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_rx_in,
    output logic [WIDTH-1:0] o_tx_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [7:0]       o_relay_cnt
);

    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TURN_W = $clog2(TURN_CYCLES + 1);
    localparam int GAP_W  = $clog2(RX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LISTEN, S_RX_LEN, S_RX_PAY, S_RX_CHK, S_TURN, S_TX, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_hdr, w_hdr_nxt;
    logic [7:0]          r_len, w_len_nxt;
    logic [7:0]          r_xor, w_xor_nxt;
    logic [8:0]          r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0]    r_gap, w_gap_nxt;
    logic [TURN_W-1:0]   r_turn, w_turn_nxt;
    logic [WIDTH-1:0]    r_tx, w_tx_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;
    logic [7:0]          r_relay, w_relay_nxt;
    logic [7:0]          r_buf [MAX_LEN];

    logic                w_buf_we;
    logic [IDX_W-1:0]    w_buf_wa;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [7:0]          w_hdr_inc;
    logic                w_valid, w_sof;
    logic [7:0]          w_data;

    assign w_valid   = i_rx_in[9];
    assign w_sof     = i_rx_in[8];
    assign w_data    = i_rx_in[7:0];
    assign w_hdr_inc = r_hdr + 8'd1;
    assign w_rd_idx  = IDX_W'(r_cnt - 9'd2);
    assign w_buf_wa  = r_cnt[IDX_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_nxt   = r_hdr;
        w_len_nxt   = r_len;
        w_xor_nxt   = r_xor;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_turn_nxt  = r_turn;
        w_tx_nxt    = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_relay_nxt = r_relay;
        w_buf_we    = 1'b0;

        if (!i_start) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_LISTEN;

                S_LISTEN: begin
                    if (w_valid && w_sof) begin
                        w_hdr_nxt   = w_data;
                        w_xor_nxt   = w_data;
                        w_cnt_nxt   = '0;
                        w_gap_nxt   = '0;
                        w_state_nxt = S_RX_LEN;
                    end
                end

                S_RX_LEN, S_RX_PAY, S_RX_CHK: begin
                    // A new SOF anywhere in a frame silently restarts capture
                    if (w_valid && w_sof) begin
                        w_hdr_nxt   = w_data;
                        w_xor_nxt   = w_data;
                        w_cnt_nxt   = '0;
                        w_gap_nxt   = '0;
                        w_state_nxt = S_RX_LEN;
                    end else if (!w_valid) begin
                        if (r_gap == GAP_W'(RX_TIMEOUT - 1)) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_LISTEN;
                        end else begin
                            w_gap_nxt = r_gap + 1'b1;
                        end
                    end else begin
                        w_gap_nxt = '0;
                        case (r_state)
                            S_RX_LEN: begin
                                w_len_nxt = w_data;
                                if (w_data == 8'd0 || w_data > 8'(MAX_LEN)) begin
                                    w_err_nxt   = 1'b1;
                                    w_state_nxt = S_LISTEN;
                                end else begin
                                    w_xor_nxt   = r_xor ^ w_data;
                                    w_cnt_nxt   = '0;
                                    w_state_nxt = S_RX_PAY;
                                end
                            end
                            S_RX_PAY: begin
                                w_buf_we  = 1'b1;
                                w_xor_nxt = r_xor ^ w_data;
                                w_cnt_nxt = r_cnt + 9'd1;
                                if (r_cnt + 9'd1 == {1'b0, r_len})
                                    w_state_nxt = S_RX_CHK;
                            end
                            default: begin
                                if (w_data == r_xor) begin
                                    w_relay_nxt = r_hdr;
                                    w_turn_nxt  = '0;
                                    w_state_nxt = ({1'b0, r_hdr} < 9'(RELAY_LIMIT)) ? S_TURN : S_DONE;
                                end else begin
                                    w_err_nxt   = 1'b1;
                                    w_state_nxt = S_LISTEN;
                                end
                            end
                        endcase
                    end
                end

                S_TURN: begin
                    if (r_turn == TURN_W'(TURN_CYCLES - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_TX;
                    end else begin
                        w_turn_nxt = r_turn + 1'b1;
                    end
                end

                S_TX: begin
                    w_cnt_nxt = r_cnt + 9'd1;
                    if (r_cnt == 9'd0) begin
                        w_tx_nxt = {2'b11, w_hdr_inc};
                    end else if (r_cnt == 9'd1) begin
                        w_tx_nxt = {2'b10, r_len};
                    end else if (r_cnt == {1'b0, r_len} + 9'd2) begin
                        // Swapping HDR for HDR+1 in the received XOR yields the new checksum
                        w_tx_nxt    = {2'b10, r_xor ^ r_hdr ^ w_hdr_inc};
                        w_state_nxt = S_DONE;
                    end else begin
                        w_tx_nxt = {2'b10, r_buf[w_rd_idx]};
                    end
                end

                S_DONE: begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_LISTEN;
                end

                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_hdr   <= '0;
            r_len   <= '0;
            r_xor   <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_turn  <= '0;
            r_tx    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_relay <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hdr   <= w_hdr_nxt;
            r_len   <= w_len_nxt;
            r_xor   <= w_xor_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_turn  <= w_turn_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_relay <= w_relay_nxt;
        end
    end

    // Payload buffer keeps its contents across reset
    always_ff @(posedge clk) begin
        if (w_buf_we)
            r_buf[w_buf_wa] <= w_data;
    end

    assign o_tx_out    = r_tx;
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_LISTEN);
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_relay_cnt = r_relay;

endmodule
